// File: rtl/ptw_axi_read_master.sv
// ptw_axi_read_master
//   Single-outstanding AXI4 read master for page-table-walk PTE fetches from
//   the instruction TLB. A one-cycle request pulse carries the address of an
//   8-byte PTE. The block issues one single-beat AXI read for it. The fetched
//   PTE comes back to the TLB as a one-cycle response pulse.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   REQ_VALID/ADDR    PTE fetch request pulse and physical address (TLB side)
//   RESP_VALID        one-cycle pulse; RESP_DATA / RESP_ERR valid
//   RESP_DATA         fetched PTE (forced to 0 on an AXI error)
//   RESP_ERR          AXI error flag for this response
//   BUSY              transaction in flight
//   REQ_DROPPED       sticky: a request arrived while BUSY
//   M_AXI_AR*         read address channel (single beat, 8 bytes, INCR)
//   M_AXI_R*          read data channel (RID and RLAST are not used)
module ptw_axi_read_master #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    output logic                  RESP_VALID,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  RESP_ERR,
    output logic                  BUSY,
    output logic                  REQ_DROPPED,
    output logic [ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  dropped_q, dropped_d;

    // Single-beat transfers make RID/RLAST redundant, and PTEs are 8-byte
    // aligned, so the low address bits are discarded.
    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_RID, M_AXI_RLAST, REQ_ADDR[2:0]};

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        dropped_d    = dropped_q;

        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    araddr_d  = {REQ_ADDR[ADDR_WIDTH-1:3], 3'b000};
                    arvalid_d = 1'b1;
                    state_d   = AR;
                end
            end
            AR: begin
                if (REQ_VALID) begin
                    dropped_d = 1'b1;
                end
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (REQ_VALID) begin
                    dropped_d = 1'b1;
                end
                if (rready_q && M_AXI_RVALID) begin
                    // An error response returns an all-zero PTE so the TLB
                    // sees an invalid entry (V bit clear).
                    if (M_AXI_RRESP == 2'b00) begin
                        resp_data_d = M_AXI_RDATA;
                        resp_err_d  = 1'b0;
                    end else begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end
                    resp_valid_d = 1'b1;
                    rready_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            dropped_q    <= dropped_d;
        end
    end

    assign BUSY          = (state_q != IDLE);
    assign RESP_VALID    = resp_valid_q;
    assign RESP_DATA     = resp_data_q;
    assign RESP_ERR      = resp_err_q;
    assign REQ_DROPPED   = dropped_q;

    assign M_AXI_ARID    = ID_WIDTH'(AXI_ID);
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b011;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARPROT  = 3'b001;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ptw_axi_read_master.sv
module tb_ptw_axi_read_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic        req_dropped;
    logic [3:0]  arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;

    ptw_axi_read_master #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .ID_WIDTH  (4),
        .AXI_ID    (0)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .REQ_VALID    (req_valid),
        .REQ_ADDR     (req_addr),
        .RESP_VALID   (resp_valid),
        .RESP_DATA    (resp_data),
        .RESP_ERR     (resp_err),
        .BUSY         (busy),
        .REQ_DROPPED  (req_dropped),
        .M_AXI_ARID   (arid),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARLEN  (arlen),
        .M_AXI_ARSIZE (arsize),
        .M_AXI_ARBURST(arburst),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RID    (rid),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RLAST  (rlast),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] rd;
        logic [1:0]  rr;
        int          ar_wait;
        int          r_wait;
        logic [63:0] exp_araddr;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge; all driving and sampling on negedges.
    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        req_valid = 1'b1;
        req_addr  = v.addr;
        @(negedge clk);
        req_valid = 1'b0;
        check({p, "_arvalid"}, 64'(arvalid), 64'd1);
        check({p, "_araddr"},  araddr, v.exp_araddr);
        check({p, "_arlen"},   64'(arlen), 64'd0);
        check({p, "_arsize"},  64'(arsize), 64'd3);
        check({p, "_arburst"}, 64'(arburst), 64'd1);
        check({p, "_arprot"},  64'(arprot), 64'd1);
        check({p, "_arid"},    64'(arid), 64'd0);
        check({p, "_busy"},    64'(busy), 64'd1);
        check({p, "_rready_ar"}, 64'(rready), 64'd0);
        for (int i = 0; i < v.ar_wait; i++) begin
            arready = 1'b0;
            @(negedge clk);
            check({p, "_arvalid_hold"}, 64'(arvalid), 64'd1);
            check({p, "_araddr_hold"},  araddr, v.exp_araddr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check({p, "_arvalid_done"}, 64'(arvalid), 64'd0);
        check({p, "_rready"},       64'(rready), 64'd1);
        for (int i = 0; i < v.r_wait; i++) begin
            @(negedge clk);
            check({p, "_resp_early"}, 64'(resp_valid), 64'd0);
            check({p, "_rready_hold"}, 64'(rready), 64'd1);
        end
        rvalid = 1'b1;
        rdata  = v.rd;
        rresp  = v.rr;
        @(negedge clk);
        rvalid = 1'b0;
        check({p, "_resp_valid"}, 64'(resp_valid), 64'd1);
        check({p, "_resp_data"},  resp_data, v.exp_data);
        check({p, "_resp_err"},   64'(resp_err), 64'(v.exp_err));
        check({p, "_busy_done"},  64'(busy), 64'd0);
        check({p, "_rready_done"}, 64'(rready), 64'd0);
        @(negedge clk);
        check({p, "_resp_pulse"},     64'(resp_valid), 64'd0);
        check({p, "_resp_data_hold"}, resp_data, v.exp_data);
        check({p, "_resp_err_hold"},  64'(resp_err), 64'(v.exp_err));
    endtask

    initial begin
        vecs[0] = '{addr: 64'h0000_0000_8000_1008, rd: 64'h0000_0000_2000_1C0F, rr: 2'b00,
                    ar_wait: 0, r_wait: 0, exp_araddr: 64'h0000_0000_8000_1008,
                    exp_data: 64'h0000_0000_2000_1C0F, exp_err: 1'b0};
        vecs[1] = '{addr: 64'h0000_0000_8000_100D, rd: 64'h1234_5678_9ABC_DEF1, rr: 2'b00,
                    ar_wait: 0, r_wait: 0, exp_araddr: 64'h0000_0000_8000_1008,
                    exp_data: 64'h1234_5678_9ABC_DEF1, exp_err: 1'b0};
        vecs[2] = '{addr: 64'h0000_0000_4000_0017, rd: 64'h0000_0000_0ABC_D00F, rr: 2'b00,
                    ar_wait: 5, r_wait: 2, exp_araddr: 64'h0000_0000_4000_0010,
                    exp_data: 64'h0000_0000_0ABC_D00F, exp_err: 1'b0};
        vecs[3] = '{addr: 64'h0000_0000_8000_2000, rd: 64'hFFFF_FFFF_FFFF_FFFF, rr: 2'b10,
                    ar_wait: 0, r_wait: 0, exp_araddr: 64'h0000_0000_8000_2000,
                    exp_data: 64'h0, exp_err: 1'b1};
        vecs[4] = '{addr: 64'h0000_0000_8000_3010, rd: 64'h0000_0000_3000_0001, rr: 2'b00,
                    ar_wait: 1, r_wait: 1, exp_araddr: 64'h0000_0000_8000_3010,
                    exp_data: 64'h0000_0000_3000_0001, exp_err: 1'b0};
        vecs[5] = '{addr: 64'h0000_0000_8000_4018, rd: 64'hAAAA_5555_AAAA_5555, rr: 2'b01,
                    ar_wait: 2, r_wait: 0, exp_araddr: 64'h0000_0000_8000_4018,
                    exp_data: 64'h0, exp_err: 1'b1};
        vecs[6] = '{addr: 64'hFFFF_FFFF_FFFF_FFFF, rd: 64'h8000_0000_0000_00CF, rr: 2'b00,
                    ar_wait: 0, r_wait: 3, exp_araddr: 64'hFFFF_FFFF_FFFF_FFF8,
                    exp_data: 64'h8000_0000_0000_00CF, exp_err: 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b1;
        rvalid    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_arvalid",  64'(arvalid), 64'd0);
        check("rst_rready",   64'(rready), 64'd0);
        check("rst_araddr",   araddr, 64'd0);
        check("rst_resp_vld", 64'(resp_valid), 64'd0);
        check("rst_resp_dat", resp_data, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_dropped",  64'(req_dropped), 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end
        check("tbl_no_drop", 64'(req_dropped), 64'd0);

        // Request while in R is dropped; request in the RESP_VALID cycle is taken.
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0000_1000;
        @(negedge clk);
        req_valid = 1'b0;
        check("drop_arvalid", 64'(arvalid), 64'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("drop_in_r", 64'(rready), 64'd1);
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0000_2000;
        @(negedge clk);
        req_valid = 1'b0;
        check("drop_no_ar",     64'(arvalid), 64'd0);
        check("drop_araddr",    araddr, 64'h1000);
        check("drop_sticky_1",  64'(req_dropped), 64'd1);
        check("drop_still_r",   64'(rready), 64'd1);
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_0D0D_0001;
        rresp  = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        check("drop_resp_vld",  64'(resp_valid), 64'd1);
        check("drop_resp_dat",  resp_data, 64'h0D0D_0001);
        check("drop_no_ar2",    64'(arvalid), 64'd0);
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0000_3005;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_arvalid",    64'(arvalid), 64'd1);
        check("b2b_araddr",     araddr, 64'h3000);
        check("b2b_resp_pulse", 64'(resp_valid), 64'd0);
        check("drop_sticky_2",  64'(req_dropped), 64'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_0E0E_0001;
        @(negedge clk);
        rvalid = 1'b0;
        check("b2b_resp_vld",   64'(resp_valid), 64'd1);
        check("b2b_resp_dat",   resp_data, 64'h0E0E_0001);
        check("drop_sticky_3",  64'(req_dropped), 64'd1);
        @(negedge clk);

        // R beat presented while idle must not be taken.
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_0F0F_0001;
        @(negedge clk);
        check("idle_rready",    64'(rready), 64'd0);
        @(negedge clk);
        rvalid = 1'b0;
        check("idle_no_resp",   64'(resp_valid), 64'd0);
        check("idle_data_hold", resp_data, 64'h0E0E_0001);

        // Reset while in R, then a late R beat.
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0000_5000;
        @(negedge clk);
        req_valid = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("mid_rst_in_r", 64'(rready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rvalid = 1'b1;
        rdata  = 64'h0000_0000_1111_0001;
        check("mid_rst_rready",   64'(rready), 64'd0);
        check("mid_rst_busy",     64'(busy), 64'd0);
        check("mid_rst_arvalid",  64'(arvalid), 64'd0);
        check("mid_rst_araddr",   araddr, 64'd0);
        check("mid_rst_resp_dat", resp_data, 64'd0);
        check("mid_rst_resp_err", 64'(resp_err), 64'd0);
        check("mid_rst_dropped",  64'(req_dropped), 64'd0);
        check("mid_rst_resp_vld", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("late_r_no_resp",   64'(resp_valid), 64'd0);
        check("late_r_busy",      64'(busy), 64'd0);
        check("late_r_rready",    64'(rready), 64'd0);
        rvalid = 1'b0;
        @(negedge clk);
        check("late_r_no_resp2",  64'(resp_valid), 64'd0);
        check("late_r_data",      resp_data, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
